// File: rtl/gouram_trace_pkg.sv
// rtl/gouram_trace_pkg.sv - shared state, flag and opcode definitions for the trace buffer
package gouram_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_GNT,
    MEM_RESP
  } state_e;

  localparam int FLAG_MEM     = 0;
  localparam int FLAG_JUMP    = 1;
  localparam int FLAG_TIMEOUT = 2;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  function automatic int rec_width(input int iw, input int aw, input int tw);
    return 4 + iw + aw + 2 * tw;
  endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// rtl/gouram_trace_fifo.sv - show-ahead record FIFO with two ordered push ports (a before b)
module gouram_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a_i,
  input  logic [WIDTH-1:0]         data_a_i,
  input  logic                     push_b_i,
  input  logic [WIDTH-1:0]         data_b_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     push_b_ok_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = LW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_b, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SW-1:0]    space;
  logic             pop_ok, acc_a, acc_b;

  // A pop in the same cycle frees its slot for an incoming push.
  always_comb begin
    pop_ok   = pop_i && (level_q != '0);
    space    = SW'(DEPTH) - SW'(level_q) + SW'(pop_ok);
    acc_a    = push_a_i && (space != '0);
    acc_b    = push_b_i && (space > SW'(acc_a));
    wr_ptr_b = wr_ptr_q + PW'(acc_a);
    wr_ptr_d = wr_ptr_b + PW'(acc_b);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    level_d  = level_q + LW'(acc_a) + LW'(acc_b) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (acc_a) mem_q[wr_ptr_q] <= data_a_i;
      if (acc_b) mem_q[wr_ptr_b] <= data_b_i;
    end
  end

  assign empty_o     = (level_q == '0);
  assign full_o      = (level_q == LW'(DEPTH));
  assign level_o     = level_q;
  assign push_b_ok_o = acc_b;
  assign data_o      = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/gouram_trace_buffer.sv
// rtl/gouram_trace_buffer.sv - timestamps retired fetches, pairs loads/stores with memory traffic, buffers records
module gouram_trace_buffer
  import gouram_trace_pkg::*;
#(
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int TIME_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter int MEM_TRACE_EN     = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 jump_done,
  input  logic                                 instr_rvalid,
  input  logic [INSTR_DATA_WIDTH-1:0]          instr_rdata,
  input  logic                                 data_mem_req,
  input  logic [DATA_ADDR_WIDTH-1:0]           data_mem_addr,
  input  logic                                 data_mem_grant,
  input  logic                                 data_mem_rvalid,
  output logic                                 trace_valid_o,
  input  logic                                 trace_ready_i,
  output logic [gouram_trace_pkg::rec_width(INSTR_DATA_WIDTH, DATA_ADDR_WIDTH, TIME_WIDTH)-1:0] trace_data_o,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level_o,
  output logic [15:0]                          drop_count_o
);

  localparam int REC_W = rec_width(INSTR_DATA_WIDTH, DATA_ADDR_WIDTH, TIME_WIDTH);
  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

  state_e                        state_q, state_d;
  logic [INSTR_DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [DATA_ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [TIME_WIDTH-1:0]         now_q, now_d, t_start_q, t_start_d;
  logic                          jump_q, jump_d;
  logic [15:0]                   wait_q, wait_d, drop_q, drop_d;

  logic             push_a, push_b, push_b_ok, lost_instr;
  logic             accept, got_resp, timed_out, is_mem;
  logic             fifo_full, fifo_empty, pop;
  logic [3:0]       flags_a, flags_b;
  logic [REC_W-1:0] rec_a, rec_b;
  logic [1:0]       lost;
  logic [16:0]      drop_sum;

  assign is_mem = (MEM_TRACE_EN != 0) &&
                  ((instr_rdata[6:0] == OPC_LOAD) || (instr_rdata[6:0] == OPC_STORE));

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    mem_addr_d = mem_addr_q;
    t_start_d  = t_start_q;
    jump_d     = jump_q | ((state_q != IDLE) & jump_done);
    wait_d     = wait_q;
    now_d      = now_q + TIME_WIDTH'(1);
    push_a     = 1'b0;
    push_b     = 1'b0;
    flags_a    = '0;
    flags_b    = '0;
    lost_instr = 1'b0;
    accept     = 1'b0;
    got_resp   = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      IDLE: accept = instr_rvalid;
      MEM_GNT: begin
        if (data_mem_req && data_mem_grant) begin
          mem_addr_d = data_mem_addr;
          wait_d     = '0;
          state_d    = MEM_RESP;
        end else if (wait_q == WAIT_LIMIT) begin
          timed_out = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      MEM_RESP: begin
        if (data_mem_rvalid) got_resp = 1'b1;
        else if (wait_q == WAIT_LIMIT) timed_out = 1'b1;
        else wait_d = wait_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // The completing record goes out on port a so a same-cycle fetch lands behind it.
    if (got_resp || timed_out) begin
      push_a                = 1'b1;
      flags_a[FLAG_MEM]     = got_resp;
      flags_a[FLAG_JUMP]    = jump_q | jump_done;
      flags_a[FLAG_TIMEOUT] = timed_out;
      state_d               = IDLE;
      accept                = instr_rvalid;
    end else if ((state_q != IDLE) && instr_rvalid) begin
      lost_instr = 1'b1;
    end

    if (accept) begin
      instr_d    = instr_rdata;
      t_start_d  = now_q;
      jump_d     = jump_done;
      mem_addr_d = '0;
      if (is_mem) begin
        state_d = MEM_GNT;
        wait_d  = '0;
      end else begin
        push_b             = 1'b1;
        flags_b[FLAG_JUMP] = jump_done;
      end
    end
  end

  assign rec_a = {flags_a, instr_q, mem_addr_q, t_start_q, now_q};
  assign rec_b = {flags_b, instr_rdata, {DATA_ADDR_WIDTH{1'b0}}, now_q, now_q};
  assign pop   = trace_valid_o & trace_ready_i;

  always_comb begin
    lost     = 2'(lost_instr) + 2'(push_a && fifo_full && !pop) + 2'(push_b && !push_b_ok);
    drop_sum = {1'b0, drop_q} + 17'(lost);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      mem_addr_q <= '0;
      t_start_q  <= '0;
      now_q      <= '0;
      jump_q     <= 1'b0;
      wait_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      mem_addr_q <= mem_addr_d;
      t_start_q  <= t_start_d;
      now_q      <= now_d;
      jump_q     <= jump_d;
      wait_q     <= wait_d;
      drop_q     <= drop_d;
    end
  end

  gouram_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_a_i    (push_a),
    .data_a_i    (rec_a),
    .push_b_i    (push_b),
    .data_b_i    (rec_b),
    .pop_i       (pop),
    .data_o      (trace_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o),
    .push_b_ok_o (push_b_ok)
  );

  assign trace_valid_o = ~fifo_empty;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_gouram_trace_buffer.sv
// tb/tb_gouram_trace_buffer.sv - scoreboard bench for gouram_trace_buffer (FIFO_DEPTH 4, MEM_TIMEOUT 4)
module tb_gouram_trace_buffer;

  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int TW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 4;
  localparam int RW    = 4 + IW + AW + 2 * TW;
  localparam int LVW   = $clog2(DEPTH) + 1;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h0002A183;
  localparam logic [31:0] SW   = 32'h0000A023;

  logic          clk, rst, jump_done, instr_rvalid;
  logic [IW-1:0] instr_rdata;
  logic          data_mem_req, data_mem_grant, data_mem_rvalid;
  logic [AW-1:0] data_mem_addr;
  logic          trace_valid_o, trace_ready_i;
  logic [RW-1:0] trace_data_o;
  logic [LVW-1:0] fifo_level_o;
  logic [15:0]   drop_count_o;

  gouram_trace_buffer #(
    .INSTR_DATA_WIDTH (IW),
    .DATA_ADDR_WIDTH  (AW),
    .TIME_WIDTH       (TW),
    .FIFO_DEPTH       (DEPTH),
    .MEM_TRACE_EN     (1),
    .MEM_TIMEOUT      (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_done       (jump_done),
    .instr_rvalid    (instr_rvalid),
    .instr_rdata     (instr_rdata),
    .data_mem_req    (data_mem_req),
    .data_mem_addr   (data_mem_addr),
    .data_mem_grant  (data_mem_grant),
    .data_mem_rvalid (data_mem_rvalid),
    .trace_valid_o   (trace_valid_o),
    .trace_ready_i   (trace_ready_i),
    .trace_data_o    (trace_data_o),
    .fifo_level_o    (fifo_level_o),
    .drop_count_o    (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   tb_now;

  always @(posedge clk) tb_now <= rst ? 32'd0 : tb_now + 32'd1;

  function automatic logic [RW-1:0] mk(input logic [3:0] f, input logic [31:0] i,
                                       input logic [31:0] a, input logic [31:0] s,
                                       input logic [31:0] e);
    return {f, i, a, s, e};
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    jump_done       = 1'b0;
    instr_rvalid    = 1'b0;
    instr_rdata     = '0;
    data_mem_req    = 1'b0;
    data_mem_addr   = '0;
    data_mem_grant  = 1'b0;
    data_mem_rvalid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_now(input logic [31:0] t);
    int k = 0;
    while (tb_now != t && k < 200) begin
      step();
      k++;
    end
    if (tb_now != t) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_now: now %0d never reached %0d", tb_now, t);
    end
  endtask

  task automatic fetch(input logic [31:0] instr, input logic jmp);
    instr_rvalid = 1'b1;
    instr_rdata  = instr;
    jump_done    = jmp;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, RW'(trace_valid_o), '0);
    chk({tag, "_level"}, RW'(fifo_level_o), '0);
    chk({tag, "_drop"},  RW'(drop_count_o), '0);
    chk({tag, "_data"},  trace_data_o, '0);
  endtask

  always @(negedge clk) begin
    if (!rst && trace_valid_o && trace_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL record: unexpected %h", trace_data_o);
      end else begin
        chk("record", trace_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    trace_ready_i = 1'b0;
    clear_inputs();
    repeat (3) step();
    check_reset_state("reset");
    rst = 1'b0;
    trace_ready_i = 1'b1;

    // Plain instruction: record on the same edge it is fetched.
    exp_q.push_back(mk(4'h0, ADDI, 32'h0, 32'd5, 32'd5));
    wait_now(5);
    fetch(ADDI, 1'b0);
    step();
    clear_inputs();
    chk("addi_valid", RW'(trace_valid_o), RW'(1));

    // Load paired with grant/rvalid, plus a back-to-back fetch on the completion edge.
    exp_q.push_back(mk(4'h1, LW, 32'h1000, 32'd10, 32'd14));
    exp_q.push_back(mk(4'h0, ADDI, 32'h0, 32'd14, 32'd14));
    wait_now(10); fetch(LW, 1'b0); step(); clear_inputs();
    wait_now(12); data_mem_req = 1'b1; data_mem_grant = 1'b1; data_mem_addr = 32'h1000;
    step(); clear_inputs();
    wait_now(14); data_mem_rvalid = 1'b1; fetch(ADDI, 1'b0); step(); clear_inputs();
    chk("dual_push_level", RW'(fifo_level_o), RW'(2));

    // Store without grant times out; a fetch during the wait is dropped.
    exp_q.push_back(mk(4'h4, SW, 32'h0, 32'd20, 32'd25));
    wait_now(20); fetch(SW, 1'b0); step(); clear_inputs();
    wait_now(22); fetch(ADDI, 1'b0); step(); clear_inputs();
    chk("wait_drop", RW'(drop_count_o), RW'(1));
    wait_now(25);
    chk("timeout_not_yet", RW'(trace_valid_o), RW'(0));
    wait_now(26);
    chk("timeout_pushed", RW'(trace_valid_o), RW'(1));

    // Jump during the response wait, then a jump on a plain instruction.
    exp_q.push_back(mk(4'h3, LW, 32'h2000, 32'd30, 32'd33));
    exp_q.push_back(mk(4'h2, ADDI, 32'h0, 32'd35, 32'd35));
    wait_now(30); fetch(LW, 1'b0); step(); clear_inputs();
    wait_now(31); data_mem_req = 1'b1; data_mem_grant = 1'b1; data_mem_addr = 32'h2000;
    step(); clear_inputs();
    wait_now(32); jump_done = 1'b1; step(); clear_inputs();
    wait_now(33); data_mem_rvalid = 1'b1; step(); clear_inputs();
    wait_now(35); fetch(ADDI, 1'b1); step(); clear_inputs();

    // Fill the FIFO with the sink stalled: four stored, two dropped.
    wait_now(39);
    trace_ready_i = 1'b0;
    wait_now(40);
    for (int i = 0; i < 6; i++) begin
      if (i < DEPTH) exp_q.push_back(mk(4'h0, ADDI, 32'h0, 32'(40 + i), 32'(40 + i)));
      fetch(ADDI, 1'b0);
      step();
    end
    clear_inputs();
    chk("full_level", RW'(fifo_level_o), RW'(4));
    chk("full_drop", RW'(drop_count_o), RW'(3));

    // Push and pop together while full.
    exp_q.push_back(mk(4'h0, ADDI, 32'h0, 32'd50, 32'd50));
    wait_now(50);
    fetch(ADDI, 1'b0);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    clear_inputs();
    chk("pushpop_level", RW'(fifo_level_o), RW'(4));
    chk("pushpop_drop", RW'(drop_count_o), RW'(3));

    trace_ready_i = 1'b1;
    begin
      int k = 0;
      while (trace_valid_o && k < 20) begin
        step();
        k++;
      end
    end
    chk("drain_level", RW'(fifo_level_o), RW'(0));
    chk("drain_sb", RW'(exp_q.size()), RW'(0));

    // Reset while a load waits with a record still buffered.
    trace_ready_i = 1'b0;
    wait_now(58); fetch(ADDI, 1'b0); step(); clear_inputs();
    wait_now(60); fetch(LW, 1'b0); step(); clear_inputs();
    wait_now(62);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midwait_reset");

    trace_ready_i = 1'b1;
    exp_q.push_back(mk(4'h0, ADDI, 32'h0, 32'd3, 32'd3));
    wait_now(3); fetch(ADDI, 1'b0); step(); clear_inputs();
    repeat (4) step();
    chk("final_sb", RW'(exp_q.size()), RW'(0));
    chk("final_drop", RW'(drop_count_o), RW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
